booth_multiplier: RTL and testbench



---
 rtl/booth_multiplier.sv | 110 +++++++++++
 tb/tb_booth_multiplier.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth multiplier: load, iterate, one-cycle booth_dv.
// Define BOOTH_UNSIGNED_EN for unsigned operands (one extra iteration).
module booth_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [WIDTH-1:0]     Multiplier,
  input  logic [WIDTH-1:0]     Multiplicand,
  output logic [2*WIDTH-1:0]   Product,
  output logic                 booth_dv,
  output logic                 busy
);

`ifdef BOOTH_UNSIGNED_EN
  localparam int QW = WIDTH + 1;
`else
  localparam int QW = WIDTH;
`endif
  localparam int AW = QW + 1;
  localparam int CW = $clog2(QW + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state;
  logic [AW-1:0]   a;
  logic [QW-1:0]   q;
  logic            q_1;
  logic [QW-1:0]   m;
  logic [CW-1:0]   cnt;

  logic [QW-1:0]   mr_in;
  logic [QW-1:0]   mc_in;
  logic [AW-1:0]   m_ext;
  logic [AW-1:0]   sum;
  logic [2*WIDTH-1:0] prod;

  // Unsigned mode widens operands by a zero MSB so the signed Booth core applies.
`ifdef BOOTH_UNSIGNED_EN
  assign mr_in = {1'b0, Multiplier};
  assign mc_in = {1'b0, Multiplicand};
  assign prod  = {a[WIDTH-2:0], q};
`else
  assign mr_in = Multiplier;
  assign mc_in = Multiplicand;
  assign prod  = {a[WIDTH-1:0], q};
`endif

  assign m_ext = {m[QW-1], m};

  always_comb begin
    sum = a;
    unique case ({q[0], q_1})
      2'b01:   sum = a + m_ext;
      2'b10:   sum = a - m_ext;
      default: sum = a;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a        <= '0;
      q        <= '0;
      q_1      <= 1'b0;
      m        <= '0;
      cnt      <= '0;
      Product  <= '0;
      booth_dv <= 1'b0;
      busy     <= 1'b0;
    end else begin
      booth_dv <= 1'b0;
      if (load) begin
        m     <= mc_in;
        q     <= mr_in;
        a     <= '0;
        q_1   <= 1'b0;
        cnt   <= CW'(QW);
        busy  <= 1'b1;
        state <= RUN;
      end else begin
        unique case (state)
          IDLE: ;
          RUN: begin
            a   <= {sum[AW-1], sum[AW-1:1]};
            q   <= {sum[0], q[QW-1:1]};
            q_1 <= q[0];
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              busy  <= 1'b0;
              state <= DONE;
            end
          end
          DONE: begin
            Product  <= prod;
            booth_dv <= 1'b1;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_booth_multiplier.sv
// Directed self-checking bench for booth_multiplier (WIDTH=4).
// Expected values follow the build mode selected by BOOTH_UNSIGNED_EN.
module tb_booth_multiplier;

  localparam int W = 4;
`ifdef BOOTH_UNSIGNED_EN
  localparam int LAT = W + 2;
  localparam int NIT = W + 1;
  localparam logic [7:0] E_BASIC = 8'h0F;
  localparam logic [7:0] E_NEG6  = 8'h1A;
  localparam logic [7:0] E_NEG56 = 8'h38;
  localparam logic [7:0] E_MIN   = 8'h40;
  localparam logic [7:0] E_ZERO  = 8'h00;
  localparam logic [7:0] E_ONES  = 8'hE1;
`else
  localparam int LAT = W + 1;
  localparam int NIT = W;
  localparam logic [7:0] E_BASIC = 8'h0F;
  localparam logic [7:0] E_NEG6  = 8'hFA;
  localparam logic [7:0] E_NEG56 = 8'hC8;
  localparam logic [7:0] E_MIN   = 8'h40;
  localparam logic [7:0] E_ZERO  = 8'h00;
  localparam logic [7:0] E_ONES  = 8'h01;
`endif
  localparam logic [7:0] E_RST  = 8'h04;
  localparam logic [7:0] E_25   = 8'h19;
  localparam logic [7:0] E_9    = 8'h09;

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic [W-1:0] mr;
  logic [W-1:0] md;
  logic [2*W-1:0] product;
  logic         dv;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int dv_cnt;
  logic [7:0] held;

  booth_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .Multiplier   (mr),
    .Multiplicand (md),
    .Product      (product),
    .booth_dv     (dv),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; leaves load low at the negedge after the accepting edge.
  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
    load = 1'b1;
    mr   = a;
    md   = b;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    mr   = ~a;
    md   = ~b;
  endtask

  task automatic wait_dv(input logic [7:0] exp, input string tag);
    int n;
    int b;
    logic seen;
    n    = 0;
    b    = busy ? 1 : 0;
    seen = 1'b0;
    while (!seen && n < 50) begin
      @(negedge clk);
      n++;
      if (dv) seen = 1'b1;
      else if (busy) b++;
    end
    chk({tag, "_seen"}, seen, 1);
    chk({tag, "_lat"}, n, LAT);
    chk({tag, "_busy"}, b, NIT);
    chk({tag, "_prod"}, product, exp);
    @(negedge clk);
    chk({tag, "_pulse"}, dv, 0);
    chk({tag, "_keep"}, product, exp);
  endtask

  initial begin
    rst  = 1'b1;
    load = 1'b0;
    mr   = '0;
    md   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_prod", product, 0);
    chk("rst_dv", dv, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);

    start(4'b0011, 4'b0101);
    wait_dv(E_BASIC, "basic");
    start(4'b1101, 4'b0010);
    wait_dv(E_NEG6, "neg6");
    start(4'b0111, 4'b1000);
    wait_dv(E_NEG56, "neg56");
    start(4'b1000, 4'b1000);
    wait_dv(E_MIN, "min");
    start(4'b0000, 4'b1011);
    wait_dv(E_ZERO, "zero");
    start(4'b1111, 4'b1111);
    wait_dv(E_ONES, "ones");

    start(4'b0011, 4'b0011);
    chk("restart_gap0", dv, 0);
    @(negedge clk);
    chk("restart_gap1", dv, 0);
    start(4'b0010, 4'b0010);
    wait_dv(E_RST, "restart");

    start(4'b0101, 4'b0101);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dv_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (dv) dv_cnt++;
    end
    chk("abort_dv", dv_cnt, 0);
    chk("abort_prod", product, 0);
    chk("abort_busy", busy, 0);
    start(4'b0101, 4'b0101);
    wait_dv(E_25, "after_rst");

    load = 1'b1;
    mr   = 4'b0010;
    md   = 4'b0010;
    @(negedge clk);
    mr   = 4'b0111;
    @(negedge clk);
    start(4'b0011, 4'b0011);
    wait_dv(E_9, "hold_load");

    held = product;
    for (int i = 0; i < 10; i++) begin
      mr = 4'(i * 3 + 1);
      md = 4'(15 - i);
      @(negedge clk);
      chk("idle_prod", product, held);
      chk("idle_dv", dv, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
